pipeline_stage_reg: RTL and testbench
=====================================

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128, width of the datapath payload (PC, operands, immediate, register addresses).
REQ-002 Parameter CTRL_W, default 16, width of the control payload (ALU/MEM/WB/branch controls).
REQ-003 Parameter CTRL_NOP, default all-zero, control value presented for bubbles and invalid slots.
REQ-004 Parameter CNT_W, default 16, width of the stall counter.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  upstream stage presents a valid instruction.
REQ-009 in_ready  output  1  stage accepts the input this cycle.
REQ-010 in_data  input  DATA_W  upstream datapath payload.
REQ-011 in_ctrl  input  CTRL_W  upstream control payload.
REQ-012 out_valid  output  1  head entry is valid.
REQ-013 out_ready  input  1  downstream stage consumes the head entry this cycle.
REQ-014 out_data  output  DATA_W  head datapath payload, all-zero when out_valid=0.
REQ-015 out_ctrl  output  CTRL_W  head control payload, CTRL_NOP when out_valid=0.
REQ-016 flush_i  input  1  discard all held entries (branch mispredict).
REQ-017 bubble_i  input  1  refuse input this cycle (hazard stall / load-use bubble).
REQ-018 stall_cnt_o  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-019 Transfer: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
REQ-020 bubble_i=1 forces in_ready=0 in the same cycle; held entries still drain normally.
REQ-021 flush_i=1 empties every entry at the next edge, including any entry accepted in the same cycle; flush takes priority over acceptance and bubble.
REQ-022 Entries leave in acceptance order; no entry is duplicated or dropped, except by flush.
REQ-023 Latency: an accepted entry appears on out_* at the next edge when the stage was empty or its head was consumed in the same cycle.
REQ-024 Full throughput: with in_valid=1, out_ready=1, and no bubble or flush, one entry is transferred per cycle.
REQ-025 Simultaneous accept and consume with one entry held: the head is replaced by the new entry and occupancy is unchanged.
REQ-026 stall_cnt_o increments by 1 in each cycle with out_valid & !out_ready, saturates at 2^CNT_W-1, and is not cleared by flush_i.
REQ-027 No combinational path from in_data or in_ctrl to out_*.

Reset
REQ-028 rst=1 at an edge: all entries empty, out_valid=0, out_data=0, out_ctrl=CTRL_NOP, stall_cnt_o=0.
REQ-029 Reset asserted mid-transfer discards held entries; no transfer completes in a reset cycle.
REQ-030 in_ready=0 while rst=1.

Configuration
REQ-031 Macro PIPE_STAGE_SKID_EN defined: the stage is a two-entry skid buffer with states EMPTY, ONE and TWO.
REQ-032 Skid transitions: EMPTY->ONE on accept; ONE->TWO on accept without consume; ONE->EMPTY on consume without accept; TWO->ONE on consume; flush from any state goes to EMPTY.
REQ-033 Skid mode: in_ready is registered, equals (state!=TWO) & !bubble_i & !rst, and has no combinational dependence on out_ready.
REQ-034 Macro PIPE_STAGE_SKID_EN undefined: the stage is a single register, and in_ready = (!out_valid | out_ready) & !bubble_i & !rst, combinational from out_ready.
REQ-035 Both builds give identical output sequences for identical accepted-input sequences.

Verification
REQ-036 Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=CTRL_NOP, stall_cnt_o=0, in_ready=0.
REQ-037 Streaming: 8 entries with data=i and out_ready=1 -> out_data 0..7 on consecutive cycles, each 1 cycle after acceptance.
REQ-038 Backpressure: out_ready=0 for 3 cycles while 2 entries are held -> stall_cnt_o=3; skid build drops in_ready after the second accept; order is preserved after release.
REQ-039 Flush: assert flush_i together with an accepting input while 2 entries are held -> the next cycle has out_valid=0, out_ctrl=CTRL_NOP and nothing remaining from before the flush.
REQ-040 Bubble: assert bubble_i for 1 cycle during streaming -> in_ready=0 in that cycle, one invalid output slot, and no loss or duplication of data.
REQ-041 Saturation: set CNT_W=4 and hold a 20-cycle stall -> stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: valid/ready pipeline register with flush, bubble and stall counter.
// Build option PIPE_STAGE_SKID_EN selects a two-entry skid buffer; default is one register.
module pipeline_stage_reg #(
  parameter int                DATA_W   = 128,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush_i,
  input  logic              bubble_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              head_vld;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] head_ctrl;
  logic              accept;
  logic              consume;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  stall_d;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              rdy_q;
  logic              rdy_d;
  logic [DATA_W-1:0] hd_q;
  logic [DATA_W-1:0] hd_d;
  logic [CTRL_W-1:0] hc_q;
  logic [CTRL_W-1:0] hc_d;
  logic [DATA_W-1:0] td_q;
  logic [DATA_W-1:0] td_d;
  logic [CTRL_W-1:0] tc_q;
  logic [CTRL_W-1:0] tc_d;

  // Ready comes from a flop so out_ready never reaches in_ready.
  assign in_ready  = rdy_q & ~bubble_i & ~rst;
  assign head_vld  = (state_q != S_EMPTY);
  assign head_data = hd_q;
  assign head_ctrl = hc_q;

  // Occupancy FSM: head always holds the oldest entry, tail the younger.
  always_comb begin
    state_d = state_q;
    hd_d    = hd_q;
    hc_d    = hc_q;
    td_d    = td_q;
    tc_d    = tc_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_ONE;
          hd_d    = in_data;
          hc_d    = in_ctrl;
        end
      end
      S_ONE: begin
        if (accept && consume) begin
          hd_d = in_data;
          hc_d = in_ctrl;
        end else if (accept) begin
          state_d = S_TWO;
          td_d    = in_data;
          tc_d    = in_ctrl;
        end else if (consume) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (consume) begin
          state_d = S_ONE;
          hd_d    = td_q;
          hc_d    = tc_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush_i) state_d = S_EMPTY;
    rdy_d = (state_d != S_TWO);
  end

  // Skid storage and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      rdy_q   <= 1'b1;
      hd_q    <= '0;
      hc_q    <= CTRL_NOP;
      td_q    <= '0;
      tc_q    <= CTRL_NOP;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      hd_q    <= hd_d;
      hc_q    <= hc_d;
      td_q    <= td_d;
      tc_q    <= tc_d;
    end
  end

`else

  logic              vld_q;
  logic              vld_d;
  logic [DATA_W-1:0] dat_q;
  logic [DATA_W-1:0] dat_d;
  logic [CTRL_W-1:0] ctl_q;
  logic [CTRL_W-1:0] ctl_d;

  // Single slot: refill allowed when empty or being drained this cycle.
  assign in_ready  = (~vld_q | out_ready) & ~bubble_i & ~rst;
  assign head_vld  = vld_q;
  assign head_data = dat_q;
  assign head_ctrl = ctl_q;

  // Slot next state; flush beats any accept in the same cycle.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    ctl_d = ctl_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (accept) begin
      vld_d = 1'b1;
      dat_d = in_data;
      ctl_d = in_ctrl;
    end else if (consume) begin
      vld_d = 1'b0;
    end
  end

  // Single-entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      ctl_q <= CTRL_NOP;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      ctl_q <= ctl_d;
    end
  end

`endif

  assign out_valid   = head_vld & ~rst;
  assign out_data    = out_valid ? head_data : '0;
  assign out_ctrl    = out_valid ? head_ctrl : CTRL_NOP;
  assign stall_cnt_o = stall_q;

  // Saturating count of held-but-not-taken cycles; flush leaves it alone.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb_pipeline_stage_reg: directed checks of pipeline_stage_reg.
// Expectations cover both the default and PIPE_STAGE_SKID_EN builds.
module tb_pipeline_stage_reg;

  localparam int          DW  = 128;
  localparam int          CW  = 16;
  localparam int          NW  = 4;
  localparam logic [15:0] NOP = 16'hA5A5;

`ifdef PIPE_STAGE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          flush_i;
  logic          bubble_i;
  logic [NW-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  pipeline_stage_reg #(
    .DATA_W  (DW),
    .CTRL_W  (CW),
    .CTRL_NOP(NOP),
    .CNT_W   (NW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .flush_i    (flush_i),
    .bubble_i   (bubble_i),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = DW'(128'hDEAD);
    in_ctrl   = 16'h00FF;
    out_ready = 1'b0;
    flush_i   = 1'b0;
    bubble_i  = 1'b0;

    // Reset held two cycles with valid input.
    tick();
    tick();
    chk("rst_vld", DW'(out_valid), DW'(0));
    chk("rst_ctl", DW'(out_ctrl), DW'(NOP));
    chk("rst_dat", out_data, DW'(0));
    chk("rst_cnt", DW'(stall_cnt_o), DW'(0));
    chk("rst_rdy", DW'(in_ready), DW'(0));

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("idle_rdy", DW'(in_ready), DW'(1));
    chk("idle_vld", DW'(out_valid), DW'(0));

    // Streaming 0..7.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = DW'(i);
      in_ctrl = CW'(i + 1);
      #1;
      chk("s_rdy", DW'(in_ready), DW'(1));
      tick();
      chk("s_vld", DW'(out_valid), DW'(1));
      chk("s_dat", out_data, DW'(i));
      chk("s_ctl", DW'(out_ctrl), DW'(i + 1));
    end
    in_valid = 1'b0;
    tick();
    chk("s_end_vld", DW'(out_valid), DW'(0));
    chk("s_end_ctl", DW'(out_ctrl), DW'(NOP));
    chk("s_end_dat", out_data, DW'(0));
    chk("s_cnt", DW'(stall_cnt_o), DW'(0));

    // Backpressure: A held, B offered, three stall cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(128'h10);
    in_ctrl   = 16'h0011;
    #1;
    chk("bp_rdyA", DW'(in_ready), DW'(1));
    tick();
    chk("bp_headA", out_data, DW'(128'h10));
    in_data = DW'(128'h20);
    in_ctrl = 16'h0021;
    #1;
    chk("bp_rdyB", DW'(in_ready), DW'(SKID));
    tick();
    chk("bp_cnt1", DW'(stall_cnt_o), DW'(1));
    chk("bp_rdy2", DW'(in_ready), DW'(0));
    tick();
    tick();
    chk("bp_cnt3", DW'(stall_cnt_o), DW'(3));
    chk("bp_hold", out_data, DW'(128'h10));
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", DW'(in_ready), DW'(!SKID));
    tick();
    in_valid = 1'b0;
    chk("bp_B_vld", DW'(out_valid), DW'(1));
    chk("bp_B_dat", out_data, DW'(128'h20));
    chk("bp_B_ctl", DW'(out_ctrl), DW'(16'h0021));
    chk("bp_cnt_keep", DW'(stall_cnt_o), DW'(3));
    tick();
    chk("bp_drain", DW'(out_valid), DW'(0));

    // Flush with entries held and an input offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(128'h30);
    in_ctrl   = 16'h0031;
    tick();
    in_data = DW'(128'h31);
    in_ctrl = 16'h0032;
    tick();
    chk("fl_pre", out_data, DW'(128'h30));
    flush_i   = 1'b1;
    out_ready = 1'b1;
    in_data   = DW'(128'h32);
    in_ctrl   = 16'h0033;
    tick();
    flush_i  = 1'b0;
    in_valid = 1'b0;
    chk("fl_vld", DW'(out_valid), DW'(0));
    chk("fl_ctl", DW'(out_ctrl), DW'(NOP));
    chk("fl_dat", out_data, DW'(0));
    chk("fl_cnt", DW'(stall_cnt_o), DW'(4));
    tick();
    chk("fl_empty", DW'(out_valid), DW'(0));

    // Bubble for one cycle during streaming.
    in_valid = 1'b1;
    in_data  = DW'(128'h40);
    in_ctrl  = 16'h0040;
    tick();
    chk("bb_d0", out_data, DW'(128'h40));
    in_data  = DW'(128'h41);
    in_ctrl  = 16'h0041;
    bubble_i = 1'b1;
    #1;
    chk("bb_rdy", DW'(in_ready), DW'(0));
    tick();
    bubble_i = 1'b0;
    chk("bb_gap", DW'(out_valid), DW'(0));
    chk("bb_gapc", DW'(out_ctrl), DW'(NOP));
    #1;
    chk("bb_rdy1", DW'(in_ready), DW'(1));
    tick();
    chk("bb_d1", out_data, DW'(128'h41));
    in_data = DW'(128'h42);
    in_ctrl = 16'h0042;
    tick();
    chk("bb_d2", out_data, DW'(128'h42));
    chk("bb_c2", DW'(out_ctrl), DW'(16'h0042));
    in_valid = 1'b0;
    tick();
    chk("bb_end", DW'(out_valid), DW'(0));
    chk("bb_cnt", DW'(stall_cnt_o), DW'(4));

    // Saturation over a 20-cycle stall.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat_rst", DW'(stall_cnt_o), DW'(0));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(128'h50);
    in_ctrl   = 16'h0050;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) chk("sat_14", DW'(stall_cnt_o), DW'(14));
    end
    chk("sat_15", DW'(stall_cnt_o), DW'(15));
    chk("sat_hold", out_data, DW'(128'h50));
    out_ready = 1'b1;
    tick();
    chk("sat_drain", DW'(out_valid), DW'(0));
    chk("sat_keep", DW'(stall_cnt_o), DW'(15));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
